// File: rtl/match_pkg.sv
// Shared types and constants for the template-matching search controller.
package match_pkg;

  localparam int unsigned DATA_W = 4000;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned POS_W  = 16;

  // Starting value for the running minimum; any real count beats it.
  localparam logic [CNT_W-1:0] CNT_ALL_ONES = '1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CMP,
    DONE
  } state_t;

endpackage

// File: rtl/linecounter.sv
// linecounter: combinational population count of a SAD result vector.
// Ports:
//   data    - SAD result vector
//   count_c - number of set bits in data (combinational)
module linecounter #(
  parameter int unsigned DATA_W = 4000,
  parameter int unsigned CNT_W  = 12
) (
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count_c
);

  // Plain adder chain; synthesis rebalances it into a tree.
  always_comb begin
    count_c = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      count_c = count_c + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/match_search_ctrl.sv
// match_search_ctrl: walks num_pos candidate positions, requests a SAD vector
// for each, reduces it to a line count and keeps the minimum and its position.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   start, num_pos          - launch a search over num_pos candidates
//   busy                    - controller not idle
//   req_valid/req_ready/req_pos     - request handshake to the SAD engine
//   sad_valid/sad_ready/sad_data    - SAD result handshake
//   done                    - one-cycle end-of-search pulse
//   best_valid/best_pos/best_count  - best match of the last search
module match_search_ctrl
  import match_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [POS_W-1:0]  num_pos,
  output logic              busy,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [POS_W-1:0]  req_pos,
  input  logic              sad_valid,
  output logic              sad_ready,
  input  logic [DATA_W-1:0] sad_data,
  output logic              done,
  output logic              best_valid,
  output logic [POS_W-1:0]  best_pos,
  output logic [CNT_W-1:0]  best_count
);

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [POS_W-1:0]   num_pos_q, num_pos_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   best_count_q, best_count_d;
  logic [POS_W-1:0]   best_pos_q, best_pos_d;
  logic               best_valid_q, best_valid_d;

  logic [CNT_W-1:0]   lc_count_c;
  logic               better_c;
  logic [CNT_W-1:0]   new_min_c;
  logic               last_c;

  linecounter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_linecounter (
    .data    (sad_data),
    .count_c (lc_count_c)
  );

  // Strict compare: ties keep the earlier position.
  assign better_c  = (count_q < best_count_q);
  assign new_min_c = better_c ? count_q : best_count_q;
  assign last_c    = (pos_q == (num_pos_q - POS_W'(1)));

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    num_pos_d    = num_pos_q;
    count_d      = count_q;
    best_count_d = best_count_q;
    best_pos_d   = best_pos_q;
    best_valid_d = best_valid_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_pos_d    = num_pos;
          pos_d        = '0;
          best_count_d = CNT_ALL_ONES;
          best_pos_d   = '0;
          best_valid_d = 1'b0;
          state_d      = (num_pos == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (req_valid && req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (sad_valid && sad_ready) begin
          count_d = lc_count_c;
          state_d = CMP;
        end
      end
      CMP: begin
        if (better_c) begin
          best_count_d = count_q;
          best_pos_d   = pos_q;
          best_valid_d = 1'b1;
        end
        // A zero count cannot be beaten, so stop early.
        if ((new_min_c == '0) || last_c) begin
          state_d = DONE;
        end else begin
          pos_d   = pos_q + POS_W'(1);
          state_d = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; handshake/status flags are
  // registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pos_q        <= '0;
      num_pos_q    <= '0;
      count_q      <= '0;
      best_count_q <= CNT_ALL_ONES;
      best_pos_q   <= '0;
      best_valid_q <= 1'b0;
      busy         <= 1'b0;
      req_valid    <= 1'b0;
      sad_ready    <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      num_pos_q    <= num_pos_d;
      count_q      <= count_d;
      best_count_q <= best_count_d;
      best_pos_q   <= best_pos_d;
      best_valid_q <= best_valid_d;
      busy         <= (state_d != IDLE);
      req_valid    <= (state_d == REQ);
      sad_ready    <= (state_d == WAIT);
      done         <= (state_d == DONE);
    end
  end

  assign req_pos    = pos_q;
  assign best_pos   = best_pos_q;
  assign best_count = best_count_q;
  assign best_valid = best_valid_q;

endmodule

// File: tb/tb_match_search_ctrl.sv
// Self-checking bench for match_search_ctrl: directed cases plus randomized
// searches compared against a simple minimum-search model.
module tb_match_search_ctrl;
  import match_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [POS_W-1:0]  num_pos;
  logic              busy;
  logic              req_valid;
  logic              req_ready;
  logic [POS_W-1:0]  req_pos;
  logic              sad_valid;
  logic              sad_ready;
  logic [DATA_W-1:0] sad_data;
  logic              done;
  logic              best_valid;
  logic [POS_W-1:0]  best_pos;
  logic [CNT_W-1:0]  best_count;

  int n_checks;
  int n_errors;

  // Per-candidate stimulus: line count, req_ready stall, sad_valid stall.
  int cnt_a [16];
  int rs_a  [16];
  int ss_a  [16];

  match_search_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_pos    (num_pos),
    .busy       (busy),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pos    (req_pos),
    .sad_valid  (sad_valid),
    .sad_ready  (sad_ready),
    .sad_data   (sad_data),
    .done       (done),
    .best_valid (best_valid),
    .best_pos   (best_pos),
    .best_count (best_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Vector with exactly k ones at a random rotation.
  function automatic logic [DATA_W-1:0] make_vec(input int k);
    logic [DATA_W-1:0] v;
    int r;
    v = '0;
    for (int i = 0; i < k; i++) v[i] = 1'b1;
    r = int'($urandom_range(0, DATA_W - 1));
    if (r != 0) v = (v << r) | (v >> (int'(DATA_W) - r));
    return v;
  endfunction

  // One complete search; cycle 0 is the edge that samples start.
  task automatic run_search(input int n, input bit disturb);
    int exp_best, exp_pos, exp_valid, exp_issued, exp_cyc;
    int req_idx, sad_idx, rcnt, scnt, done_cyc;
    bit pend_req, pulsed, overrun;

    // Reference: linear minimum search with early stop on zero.
    exp_best = 4095; exp_pos = 0; exp_valid = 0; exp_issued = 0; exp_cyc = 1;
    for (int i = 0; i < n; i++) begin
      exp_issued++;
      exp_cyc += 3 + rs_a[i] + ss_a[i];
      if (cnt_a[i] < exp_best) begin
        exp_best = cnt_a[i]; exp_pos = i; exp_valid = 1;
      end
      if (exp_best == 0) break;
    end

    @(negedge clk);
    start = 1'b1; num_pos = POS_W'(n); req_ready = 1'b0; sad_valid = 1'b0;
    req_idx = 0; sad_idx = 0; rcnt = 0; scnt = 0; done_cyc = -1;
    pend_req = 1'b0; pulsed = 1'b0; overrun = 1'b0;

    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk);
      start = 1'b0; req_ready = 1'b0; sad_valid = 1'b0;
      if (pend_req) check("req_hold", req_valid, 1);
      pend_req = 1'b0;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (req_valid) begin
        if (req_idx >= n) begin overrun = 1'b1; break; end
        check("req_pos", req_pos, req_idx);
        if (rcnt < rs_a[req_idx]) begin
          rcnt++; pend_req = 1'b1;
        end else begin
          req_ready = 1'b1; req_idx++; rcnt = 0;
        end
        // Zero-count vector offered outside WAIT must be ignored.
        if (disturb) begin sad_valid = 1'b1; sad_data = make_vec(0); end
      end
      if (sad_ready) begin
        if (sad_idx >= n) begin overrun = 1'b1; break; end
        if (disturb && !pulsed) begin
          start = 1'b1; num_pos = POS_W'(1); pulsed = 1'b1;
        end
        if (scnt < ss_a[sad_idx]) begin
          scnt++;
        end else begin
          sad_valid = 1'b1; sad_data = make_vec(cnt_a[sad_idx]); sad_idx++; scnt = 0;
        end
      end
    end

    check("overrun", overrun, 0);
    check("done_cycle", done_cyc, exp_cyc);
    check("best_valid", best_valid, exp_valid);
    check("best_pos", best_pos, exp_pos);
    check("best_count", best_count, exp_best);
    check("req_issued", req_idx, exp_issued);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
    check("best_hold", best_count, exp_best);
  endtask

  // Reset during CMP of the 2nd of 3 zero-wait candidates.
  task automatic run_reset();
    int pulses;
    @(negedge clk);
    start = 1'b1; num_pos = POS_W'(3); req_ready = 1'b1; sad_valid = 1'b1;
    sad_data = make_vec(200);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("rst_pre_busy", busy, 1);
    check("rst_pre_reqv", req_valid, 0);
    check("rst_pre_sadr", sad_ready, 0);
    check("rst_pre_best", best_count, 200);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; req_ready = 1'b0; sad_valid = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_req_pos", req_pos, 0);
    check("rst_sad_ready", sad_ready, 0);
    check("rst_done", done, 0);
    check("rst_best_valid", best_valid, 0);
    check("rst_best_pos", best_pos, 0);
    check("rst_best_count", best_count, 4095);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("rst_no_done", pulses, 0);
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 16; i++) begin
      rs_a[i] = 0; ss_a[i] = 0; cnt_a[i] = 0;
    end
  endtask

  initial begin
    int n;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start = 1'b0; num_pos = '0;
    req_ready = 1'b0; sad_valid = 1'b0; sad_data = '0;

    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_req_valid", req_valid, 0);
    check("reset_req_pos", req_pos, 0);
    check("reset_sad_ready", sad_ready, 0);
    check("reset_done", done, 0);
    check("reset_best_valid", best_valid, 0);
    check("reset_best_pos", best_pos, 0);
    check("reset_best_count", best_count, 4095);
    rst_n = 1'b1;
    @(negedge clk);

    clear_stalls();
    cnt_a[0] = 100; cnt_a[1] = 50; cnt_a[2] = 75; cnt_a[3] = 50;
    run_search(4, 1'b0);

    clear_stalls();
    cnt_a[0] = 300; cnt_a[1] = 0; cnt_a[2] = 20; cnt_a[3] = 30; cnt_a[4] = 40;
    run_search(5, 1'b0);

    clear_stalls();
    run_search(0, 1'b0);

    clear_stalls();
    cnt_a[0] = 4000; cnt_a[1] = 4000;
    rs_a[0] = 3; rs_a[1] = 3; ss_a[0] = 2; ss_a[1] = 2;
    run_search(2, 1'b0);

    clear_stalls();
    cnt_a[0] = 100; cnt_a[1] = 50; cnt_a[2] = 75; cnt_a[3] = 50;
    run_search(4, 1'b1);

    run_reset();

    for (int t = 0; t < 25; t++) begin
      n = int'($urandom_range(1, 10));
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 9))
          0:       cnt_a[i] = 0;
          1, 2:    cnt_a[i] = 20;
          3:       cnt_a[i] = 4000;
          default: cnt_a[i] = int'($urandom_range(1, 4000));
        endcase
        rs_a[i] = int'($urandom_range(0, 3));
        ss_a[i] = int'($urandom_range(0, 3));
      end
      run_search(n, t[0]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
